chunked_serial_adder: RTL and testbench
=======================================

Name: chunked_serial_adder

Overview:
- Multi-cycle add/subtract unit; parameterised successor to the 4-bit ripple-carry adder.
- Processes WIDTH-bit operands CHUNK bits per cycle, LSB chunk first, using a CHUNK-wide ripple chain. The carry is registered between chunks.
- Valid/ready handshake on both sides, so it can sit in datapaths where a full-width combinational ripple would miss timing.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH.
- N (localparam), WIDTH/CHUNK, number of chunk cycles per operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  unit can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in; set to 1 for plain subtraction.
- sub  input  1  0: A+B+cin; 1: A+~B+cin.
- out_valid  output  1  result held and valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB; for subtraction, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset: one clock with rst high gives state=IDLE, sum=0, cout=0, ovf=0, out_valid=0, chunk index=0, carry register=0. in_ready is forced to 0 while rst is high and is 1 on the first cycle after reset deasserts.
- Reset mid-operation (RUN or DONE): the operation is aborted with no out_valid pulse and all registers return to their reset values.
- Elaboration: WIDTH % CHUNK != 0, or CHUNK > WIDTH, is a fatal elaboration error.
- States:
  - IDLE: in_ready=1, out_valid=0. If in_valid is high at an edge, latch A, B'=B^{WIDTH{sub}}, carry=cin, index k=0, go to RUN.
  - RUN: in_ready=0. Each edge computes {c, s} = A[k] + B'[k] + carry over chunk k (bits k*CHUNK..k*CHUNK+CHUNK-1), writes s into sum chunk k, sets carry=c, and increments k. On the edge processing k=N-1: cout=c, ovf=(A_msb==B'_msb)&&(sum_msb!=A_msb), go to DONE.
  - DONE: out_valid=1, in_ready=0. sum, cout and ovf are stable. If out_ready is high at an edge, go to IDLE; otherwise hold.
- Timing: out_valid rises N edges after the accepting edge. Minimum issue interval is N+2 cycles (accept, N chunks, handshake).
- Inputs while not IDLE: in_valid and a/b/cin/sub are ignored; operands are latched only at acceptance and may change freely afterwards.
- Output stability: sum is only meaningful while out_valid is high. During RUN it changes chunk by chunk.
- out_ready while out_valid is low has no effect.
- N=1 (CHUNK=WIDTH): a single RUN cycle gives latency 1. It must behave identically to a full combinational ripple adder.
- Wrap-around: overflow of the full sum drops off the MSB into cout. There is no saturation.
- Carry propagates across chunk boundaries only through the carry register; there is no combinational path between chunks.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
- Add 0x1234+0x4321, cin=0, sub=0:
  - Required: sum=0x5555, cout=0, ovf=0.
  - Required: out_valid rises exactly 4 edges after acceptance and busy is high throughout.
- Full carry chain, 0xFFFF+0x0001, cin=0: sum=0x0000, cout=1, ovf=0. Signed overflow, 0x7FFF+0x0001: sum=0x8000, cout=0, ovf=1.
- Subtract, sub=1, cin=1:
  - 0x0005-0x0007: sum=0xFFFE, cout=0, ovf=0.
  - 0x8000-0x0001: sum=0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while pulsing in_valid with new operands.
  - Required: sum, cout and ovf stay frozen and in_ready=0.
  - Required: after out_ready=1, in_ready=1 on the next cycle and the next op is accepted and computes correctly.
- Reset mid-RUN after 2 chunks:
  - Required: the cycle after the reset edge shows sum=0, out_valid=0, busy=0, in_ready=1, with no out_valid pulse from the aborted op.
  - Required: the next op 0x00FF+0x0001 gives 0x0100.
- Second instance with WIDTH=16, CHUNK=16, random 500-vector regression plus back-to-back issue, all against a reference model A+(B^mask)+cin:
  - Required: latency 1 and issue interval 3.
  - Required: the CHUNK=4 instance issue interval is 6.

Source files
------------

// File: rtl/chunked_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : chunked_serial_adder
// Description : Multi-cycle add/subtract, CHUNK bits per cycle, LSB chunk first,
//               with the inter-chunk carry held in a register.
// Revision    : 1.0
// ============================================================================
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] c_last_k = KW'(N - 1);

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $fatal(1, "chunked_serial_adder: WIDTH must be a multiple of CHUNK and CHUNK <= WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [KW-1:0]    r_k;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;
    logic             r_busy;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_s;
    logic             w_c;

    // Select the operand chunk for the current index and add it with the stored carry.
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int i = 0; i < N; i++) begin
            if (r_k == KW'(i)) begin
                w_a_chunk = r_a[i*CHUNK +: CHUNK];
                w_b_chunk = r_b[i*CHUNK +: CHUNK];
            end
        end
        {w_c, w_s} = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_k         <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= cin;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (r_k == KW'(i)) begin
                            r_sum[i*CHUNK +: CHUNK] <= w_s;
                        end
                    end
                    r_carry <= w_c;
                    if (r_k == c_last_k) begin
                        // The chunk MSB written this cycle is the result MSB.
                        r_k         <= '0;
                        r_cout      <= w_c;
                        r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                       (w_s[CHUNK-1] != r_a[WIDTH-1]);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // in_ready is masked by rst so it reads low during reset and high the cycle it releases.
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_chunked_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_chunked_serial_adder
// Description : Self-checking bench for chunked_serial_adder, CHUNK=4 and CHUNK=16.
// Revision    : 1.0
// ============================================================================
module tb_chunked_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv;
    logic        ordy;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    int          sel;

    always #5 clk = ~clk;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, cout4, ovf4, busy4;
    logic        in_valid16, in_ready16, out_valid16, out_ready16, cout16, ovf16, busy16;
    logic [15:0] sum4, sum16;

    assign in_valid4   = iv && (sel == 0);
    assign in_valid16  = iv && (sel == 1);
    assign out_ready4  = ordy && (sel == 0);
    assign out_ready16 = ordy && (sel == 1);

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4)
    );

    chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .ovf(ovf16), .busy(busy16)
    );

    logic        m_in_ready, m_out_valid, m_cout, m_ovf, m_busy;
    logic [15:0] m_sum;
    assign m_in_ready  = (sel == 0) ? in_ready4  : in_ready16;
    assign m_out_valid = (sel == 0) ? out_valid4 : out_valid16;
    assign m_cout      = (sel == 0) ? cout4      : cout16;
    assign m_ovf       = (sel == 0) ? ovf4       : ovf16;
    assign m_busy      = (sel == 0) ? busy4      : busy16;
    assign m_sum       = (sel == 0) ? sum4       : sum16;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Reference: whole-word arithmetic, result packed as {ovf, cout, sum}.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mc, input logic ms);
        logic [15:0] bm;
        logic [16:0] full;
        logic        v;
        bm   = ms ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bm} + {16'd0, mc};
        v    = ($signed(ma) >= 0) == ($signed(bm) >= 0) &&
               (($signed(full[15:0]) >= 0) != ($signed(ma) >= 0));
        return {v, full[16], full[15:0]};
    endfunction

    task automatic issue(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic ts);
        int guard = 0;
        while (m_in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) timeout("issue_in_ready");
        a = ta; b = tb; cin = tc; sub = ts;
        iv = 1'b1;
        @(posedge clk); #1;
        iv  = 1'b0;
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic wait_done(output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (m_out_valid !== 1'b1 && lat < 50) begin
            if (m_busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 50) timeout("wait_out_valid");
    endtask

    task automatic release_result();
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
    endtask

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic ts,
                         output logic [17:0] res, output int lat, output bit busy_ok);
        issue(ta, tb, tc, ts);
        wait_done(lat, busy_ok);
        res = {m_ovf, m_cout, m_sum};
        release_result();
    endtask

    // Hold in_valid and out_ready high and measure spacing between result pulses.
    task automatic stream(input int exp_int, input string tag);
        int          last = -1;
        int          n_int = 0;
        logic        prev = 1'b0;
        logic [17:0] exp = model(16'h1357, 16'h2468, 1'b1, 1'b0);
        a = 16'h1357; b = 16'h2468; cin = 1'b1; sub = 1'b0;
        iv = 1'b1; ordy = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            if (m_out_valid && !prev) begin
                chk({tag, "_stream_result"}, {14'd0, m_ovf, m_cout, m_sum}, {14'd0, exp});
                if (last >= 0) begin
                    chk({tag, "_issue_interval"}, 32'(cyc - last), 32'(exp_int));
                    n_int++;
                end
                last = cyc;
            end
            prev = m_out_valid;
        end
        if (n_int == 0) timeout({tag, "_stream_no_results"});
        iv = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        ordy = 1'b0;
    endtask

    initial begin
        logic [17:0] res;
        logic [17:0] exp;
        int          lat;
        bit          busy_ok;
        bit          seen;

        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1; iv = 1'b0; ordy = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; sel = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("in_ready_during_rst", {31'd0, m_in_ready}, 32'd0);
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk($sformatf("rst_in_ready_u%0d", s),  {31'd0, m_in_ready},  32'd1);
            chk($sformatf("rst_sum_u%0d", s),       {16'd0, m_sum},       32'd0);
            chk($sformatf("rst_cout_ovf_u%0d", s),  {30'd0, m_cout, m_ovf}, 32'd0);
            chk($sformatf("rst_out_valid_u%0d", s), {31'd0, m_out_valid}, 32'd0);
            chk($sformatf("rst_busy_u%0d", s),      {31'd0, m_busy},      32'd0);
        end

        // Directed vectors on both instances.
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int i = 0; i < 8; i++) begin
                do_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, res, lat, busy_ok);
                chk($sformatf("vec%0d_u%0d_sum", i, s),  {16'd0, res[15:0]}, {16'd0, tbl[i].sum});
                chk($sformatf("vec%0d_u%0d_cout", i, s), {31'd0, res[16]},   {31'd0, tbl[i].cout});
                chk($sformatf("vec%0d_u%0d_ovf", i, s),  {31'd0, res[17]},   {31'd0, tbl[i].ovf});
                chk($sformatf("vec%0d_u%0d_latency", i, s), 32'(lat), (s == 0) ? 32'd4 : 32'd1);
                chk($sformatf("vec%0d_u%0d_busy", i, s), {31'd0, busy_ok}, 32'd1);
            end
        end

        // Backpressure on the CHUNK=4 unit with new operands offered meanwhile.
        sel = 0;
        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_done(lat, busy_ok);
        for (int c = 0; c < 10; c++) begin
            iv = (c % 2) == 0;
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
            chk("bp_sum",       {16'd0, m_sum},       32'h5555);
            chk("bp_cout_ovf",  {30'd0, m_cout, m_ovf}, 32'd0);
            chk("bp_in_ready",  {31'd0, m_in_ready},  32'd0);
            chk("bp_out_valid", {31'd0, m_out_valid}, 32'd1);
        end
        iv = 1'b0;
        release_result();
        chk("bp_in_ready_after", {31'd0, m_in_ready}, 32'd1);
        do_op(16'h0F0F, 16'h0101, 1'b1, 1'b0, res, lat, busy_ok);
        exp = model(16'h0F0F, 16'h0101, 1'b1, 1'b0);
        chk("bp_next_op", {14'd0, res}, {14'd0, exp});

        // Reset after two chunks of an op.
        issue(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_sum",       {16'd0, m_sum},       32'd0);
        chk("midrst_out_valid", {31'd0, m_out_valid}, 32'd0);
        chk("midrst_busy",      {31'd0, m_busy},      32'd0);
        chk("midrst_in_ready",  {31'd0, m_in_ready},  32'd1);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (m_out_valid) seen = 1'b1;
        end
        chk("midrst_no_pulse", {31'd0, seen}, 32'd0);
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, res, lat, busy_ok);
        chk("midrst_next_sum", {16'd0, res[15:0]}, 32'h0100);

        // Back-to-back issue interval.
        sel = 0;
        stream(6, "c4");
        sel = 1;
        stream(3, "c16");

        // Random regression against the reference model.
        for (int s = 1; s >= 0; s--) begin
            sel = s;
            for (int i = 0; i < ((s == 1) ? 500 : 100); i++) begin
                logic [15:0] ra, rb;
                logic        rc, rs;
                ra = 16'($urandom); rb = 16'($urandom);
                rc = 1'($urandom);  rs = 1'($urandom);
                do_op(ra, rb, rc, rs, res, lat, busy_ok);
                exp = model(ra, rb, rc, rs);
                chk($sformatf("rand_u%0d_a%h_b%h_c%0d_s%0d", s, ra, rb, rc, rs),
                    {14'd0, res}, {14'd0, exp});
                chk($sformatf("rand_u%0d_latency", s), 32'(lat), (s == 0) ? 32'd4 : 32'd1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
